alu_result_capture: RTL and testbench
=====================================

Name: alu_result_capture

Overview:
- Downstream stage of the 4-bit ALU (main_circuit).
- Samples all four ALU result buses plus the 2-bit select s on a valid/ready handshake.
- Selects the result for the active operation and attaches status flags.
- Buffers results in a small FIFO so a slower consumer (display/UART formatter) drains them at its own pace.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU outputs and s are stable and valid this cycle.
- in_ready  output  1  capture stage can accept an entry.
- s  input  2  ALU select: 00 add, 01 subtract, 10 compare, 11 AND.
- adder  input  5  ALU sum, bit4 = carry.
- subs  input  5  ALU difference, bit4 = borrow.
- comp  input  3  comparator {greater, equal, lesser}.
- and_op  input  4  bitwise AND.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_op  output  2  op code of the head entry.
- out_res  output  5  selected result of the head entry.
- out_zero  output  1  head out_res == 0.
- out_cy  output  1  head carry/borrow; 0 for compare and AND.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- ops_done  output  CNT_W  count of accepted captures.

Behaviour:
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- Result selection, combinational at push:
  - 00: res = adder.
  - 01: res = subs.
  - 10: res = {2'b00, comp}.
  - 11: res = {1'b0, and_op}.
- Flags at push:
  - zero = (res == 0).
  - cy = res[4] for op 00/01, else 0.
- Each entry stores {op, res, zero, cy} = 9 bits.
- in_ready = (fifo_count != DEPTH). No full bypass: when full, in_ready = 0 even if a pop occurs in the same cycle.
- out_valid = (fifo_count != 0). Outputs are driven from the registered head entry; data is undefined-free (holds the last written value) when empty.
- Latency: an entry pushed at edge N gives out_valid = 1 after edge N when the FIFO was empty. There is no combinational path from inputs to outputs.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pop when empty: impossible by definition; out_ready is ignored.
- in_valid while full: no capture, no counter change. The upstream must hold its data.
- Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH, and count tracks fullness.
- ops_done increments by 1 on every push and wraps 2^CNT_W-1 -> 0.
- Comp values 000, or more than one bit set, are captured verbatim with no error.
- Reset (asynchronous, any time including mid-handshake): pointers = 0, fifo_count = 0, ops_done = 0, out_valid = 0, in_ready = 1, out_op/out_res/out_zero/out_cy = 0. Storage contents need not be cleared, but outputs read 0 until the first push.
- Structure: single-clock FSM-free FIFO, one always block per register group.

Optional Feature:
- Macro: ALU_CAPTURE_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit) = even parity (XOR) over the stored {op, res}, computed at push and stored per entry.
  - out_par resets to 0.
  - Entry width becomes 10 bits.
- Undefined: no out_par port; entry width is 9 bits; all other behaviour is identical.

Test Plan:
- Reset then push s=00, adder=5'b10011 with out_ready=0 -> next cycle out_valid=1, out_op=00, out_res=10011, out_cy=1, out_zero=0, fifo_count=1, ops_done=1.
- Push s=10, comp=3'b010 then s=11, and_op=4'b0000 -> heads pop in order: res=00010, cy=0, zero=0; then res=00000, zero=1, cy=0.
- out_ready=0, in_valid=1 for 6 cycles with DEPTH=4 -> fifo_count reaches 4, in_ready=0, ops_done=4. Draining with out_ready=1 returns the 4 entries in FIFO order.
- Full FIFO, in_valid=1 and out_ready=1 together -> pop only, count 4->3. In the next cycle push+pop keep count at 3.
- Assert rst for one cycle with count=3 mid-transfer -> out_valid=0, fifo_count=0, ops_done=0, in_ready=1 immediately, without waiting for a clock edge.
- ALU_CAPTURE_PARITY_EN defined, push s=01, subs=5'b00111 -> out_par = ^{2'b01, 5'b00111} = 0.

Source files
------------

// File: rtl/alu_result_capture.sv
// alu_result_capture: downstream capture stage of the 4-bit ALU.
// Samples the ALU result buses on a valid/ready handshake, selects the
// result for the active op, attaches zero/carry flags and buffers entries
// in a small FIFO for a slower consumer. All outputs come from registers.
// Optional feature macro: ALU_CAPTURE_PARITY_EN adds out_par, the even
// parity over the stored {op, res}, kept per entry.
module alu_result_capture #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 s,
  input  logic [4:0]                 adder,
  input  logic [4:0]                 subs,
  input  logic [2:0]                 comp,
  input  logic [3:0]                 and_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_op,
  output logic [4:0]                 out_res,
  output logic                       out_zero,
  output logic                       out_cy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [CNT_W-1:0]           ops_done
`ifdef ALU_CAPTURE_PARITY_EN
  ,
  output logic                       out_par
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned FC_W  = PTR_W + 1;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] res;
    logic       zero;
    logic       cy;
`ifdef ALU_CAPTURE_PARITY_EN
    logic       par;
`endif
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head_q;
  entry_t           head_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_inc;
  logic [FC_W-1:0]  count_nxt;
  logic             push_c;
  logic             pop_c;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;
  assign rd_inc = rd_ptr + PTR_W'(1);

  // Select the active op's result and derive its flags.
  always_comb begin
    new_entry = '0;
    new_entry.op = s;
    unique case (s)
      2'b00: begin
        new_entry.res = adder;
        new_entry.cy  = adder[4];
      end
      2'b01: begin
        new_entry.res = subs;
        new_entry.cy  = subs[4];
      end
      2'b10:   new_entry.res = {2'b00, comp};
      default: new_entry.res = {1'b0, and_op};
    endcase
    new_entry.zero = (new_entry.res == 5'd0);
`ifdef ALU_CAPTURE_PARITY_EN
    new_entry.par = ^{new_entry.op, new_entry.res};
`endif
  end

  // Next occupancy from the push/pop combination.
  always_comb begin
    count_nxt = fifo_count;
    if (push_c && !pop_c) begin
      count_nxt = fifo_count + FC_W'(1);
    end else if (!push_c && pop_c) begin
      count_nxt = fifo_count - FC_W'(1);
    end
  end

  // Next head: the entry after the popped one, or the new entry when it
  // lands in the head slot (empty FIFO, or single entry popped while pushing).
  always_comb begin
    head_nxt = head_q;
    if (pop_c) begin
      if (fifo_count != FC_W'(1)) begin
        head_nxt = mem[rd_inc];
      end else if (push_c) begin
        head_nxt = new_entry;
      end
    end else if (push_c && (fifo_count == FC_W'(0))) begin
      head_nxt = new_entry;
    end
  end

  // Entry storage; not reset, the registered head masks stale contents.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointers, occupancy and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_inc;
      fifo_count <= count_nxt;
      in_ready   <= (count_nxt != FC_W'(DEPTH));
      out_valid  <= (count_nxt != FC_W'(0));
    end
  end

  // Registered head entry feeding the output ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
    end else begin
      head_q <= head_nxt;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (push_c) begin
      ops_done <= ops_done + CNT_W'(1);
    end
  end

  assign out_op   = head_q.op;
  assign out_res  = head_q.res;
  assign out_zero = head_q.zero;
  assign out_cy   = head_q.cy;
`ifdef ALU_CAPTURE_PARITY_EN
  assign out_par  = head_q.par;
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Self-checking bench for alu_result_capture: table vectors plus directed
// multi-cycle sequences, with a scoreboard queue of expected head entries.
module tb_alu_result_capture;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned FC_W  = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       s = '0;
  logic [4:0]       adder = '0;
  logic [4:0]       subs = '0;
  logic [2:0]       comp = '0;
  logic [3:0]       and_op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_op;
  logic [4:0]       out_res;
  logic             out_zero;
  logic             out_cy;
  logic [FC_W-1:0]  fifo_count;
  logic [CNT_W-1:0] ops_done;
`ifdef ALU_CAPTURE_PARITY_EN
  logic             out_par;
`endif

  alu_result_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .adder(adder), .subs(subs), .comp(comp), .and_op(and_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_res(out_res), .out_zero(out_zero), .out_cy(out_cy),
    .fifo_count(fifo_count), .ops_done(ops_done)
`ifdef ALU_CAPTURE_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] res;
    logic       zero;
    logic       cy;
  } exp_t;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic [4:0] a;
    logic [4:0] b;
    logic [2:0] c;
    logic [3:0] d;
    logic       r;
    logic [4:0] res;
    logic       zero;
    logic       cy;
  } vec_t;

  exp_t sb[$];
  int   mcount = 0;
  int   mops   = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference for the random section.
  function automatic exp_t model(input logic [1:0] sel, input logic [4:0] a,
                                 input logic [4:0] b, input logic [2:0] c,
                                 input logic [3:0] d);
    exp_t e;
    e.op = sel;
    e.cy = 1'b0;
    case (sel)
      2'd0: begin e.res = a; e.cy = a[4]; end
      2'd1: begin e.res = b; e.cy = b[4]; end
      2'd2: e.res = {2'b00, c};
      default: e.res = {1'b0, d};
    endcase
    e.zero = (e.res == 5'd0);
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mcount != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mcount != DEPTH));
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(mcount));
    chk({tag, ".ops_done"}, 32'(ops_done), 32'(mops));
    if (sb.size() > 0) begin
      chk({tag, ".out_op"}, 32'(out_op), 32'(sb[0].op));
      chk({tag, ".out_res"}, 32'(out_res), 32'(sb[0].res));
      chk({tag, ".out_zero"}, 32'(out_zero), 32'(sb[0].zero));
      chk({tag, ".out_cy"}, 32'(out_cy), 32'(sb[0].cy));
`ifdef ALU_CAPTURE_PARITY_EN
      chk({tag, ".out_par"}, 32'(out_par), 32'(^{sb[0].op, sb[0].res}));
`endif
    end
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] sel,
                      input logic [4:0] a, input logic [4:0] b, input logic [2:0] c,
                      input logic [3:0] d, input logic r, input exp_t e);
    bit push, pop;
    push = v && (mcount != DEPTH);
    pop  = r && (mcount != 0);
    in_valid = v; s = sel; adder = a; subs = b; comp = c; and_op = d; out_ready = r;
    @(posedge clk);
    #1;
    if (pop) void'(sb.pop_front());
    if (push) begin
      sb.push_back(e);
      mops = (mops + 1) % (1 << CNT_W);
    end
    mcount = mcount + int'(push) - int'(pop);
    check_outputs(tag);
  endtask

  task automatic rand_step(input string tag, input logic v, input logic r);
    logic [1:0] sel;
    logic [4:0] a, b;
    logic [2:0] c;
    logic [3:0] d;
    sel = 2'($urandom); a = 5'($urandom); b = 5'($urandom);
    c = 3'($urandom); d = 4'($urandom);
    step(tag, v, sel, a, b, c, d, r, model(sel, a, b, c, d));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, ".ops_done"}, 32'(ops_done), 32'd0);
    chk({tag, ".out_op"}, 32'(out_op), 32'd0);
    chk({tag, ".out_res"}, 32'(out_res), 32'd0);
    chk({tag, ".out_zero"}, 32'(out_zero), 32'd0);
    chk({tag, ".out_cy"}, 32'(out_cy), 32'd0);
`ifdef ALU_CAPTURE_PARITY_EN
    chk({tag, ".out_par"}, 32'(out_par), 32'd0);
`endif
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{1'b1, 2'b00, 5'b00101, 5'b11111, 3'b111, 4'b1111, 1'b0, 5'b00101, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'b01, 5'b01010, 5'b10001, 3'b100, 4'b0110, 1'b0, 5'b10001, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 2'b10, 5'b11111, 5'b11111, 3'b000, 4'b1111, 1'b1, 5'b00000, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 2'b10, 5'b00001, 5'b00010, 3'b111, 4'b1000, 1'b0, 5'b00111, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'b11, 5'b10101, 5'b10110, 3'b010, 4'b1010, 1'b1, 5'b01010, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 2'b00, 5'b00000, 5'b11000, 3'b001, 4'b1111, 1'b1, 5'b00000, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 2'b00, 5'b11111, 5'b00000, 3'b000, 4'b0000, 1'b1, 5'b11111, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 2'b01, 5'b11100, 5'b00111, 3'b101, 4'b0101, 1'b0, 5'b00111, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 2'b00, 5'b10000, 5'b01111, 3'b011, 4'b0011, 1'b1, 5'b10000, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 2'b11, 5'b11111, 5'b11111, 3'b111, 4'b0000, 1'b1, 5'b00000, 1'b1, 1'b0};

    // Initial reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // First push: add with carry, consumer stalled
    e = '{2'b00, 5'b10011, 1'b0, 1'b1};
    step("push_add", 1'b1, 2'b00, 5'b10011, 5'b00000, 3'b000, 4'b0000, 1'b0, e);
    chk("push_add.res_lit", 32'(out_res), 32'h13);
    chk("push_add.cy_lit", 32'(out_cy), 32'd1);
    // Drain it
    step("drain1", 1'b0, 2'b00, 5'b0, 5'b0, 3'b0, 4'b0, 1'b1, e);

    // Compare then zero AND, popped in order
    e = '{2'b10, 5'b00010, 1'b0, 1'b0};
    step("push_cmp", 1'b1, 2'b10, 5'b11111, 5'b11111, 3'b010, 4'b1111, 1'b0, e);
    e = '{2'b11, 5'b00000, 1'b1, 1'b0};
    step("push_and0", 1'b1, 2'b11, 5'b11111, 5'b11111, 3'b111, 4'b0000, 1'b0, e);
    step("pop_cmp", 1'b0, 2'b00, 5'b0, 5'b0, 3'b0, 4'b0, 1'b1, e);
    chk("pop_cmp.zero_lit", 32'(out_zero), 32'd1);
    step("pop_and0", 1'b0, 2'b00, 5'b0, 5'b0, 3'b0, 4'b0, 1'b1, e);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      e = '{tbl[i].s, tbl[i].res, tbl[i].zero, tbl[i].cy};
      step($sformatf("tbl%0d", i), tbl[i].v, tbl[i].s, tbl[i].a, tbl[i].b,
           tbl[i].c, tbl[i].d, tbl[i].r, e);
    end
    while (mcount != 0) rand_step("drain_tbl", 1'b0, 1'b1);

    // Fill past full: six valid cycles with consumer stalled
    for (int i = 0; i < 6; i++) rand_step("fill", 1'b1, 1'b0);
    chk("full.in_ready_lit", 32'(in_ready), 32'd0);
    chk("full.count_lit", 32'(fifo_count), 32'd4);
    // Full with push and pop requested: pop only
    rand_step("full_pushpop", 1'b1, 1'b1);
    chk("full_pushpop.count_lit", 32'(fifo_count), 32'd3);
    // Push+pop at count 3 keeps count
    rand_step("mid_pushpop", 1'b1, 1'b1);
    chk("mid_pushpop.count_lit", 32'(fifo_count), 32'd3);

    // Asynchronous reset mid-transfer
    in_valid = 1'b1;
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    sb.delete();
    mcount = 0;
    mops = 0;
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    rst = 1'b0;
    in_valid = 1'b0;

    // Steady push+pop long enough to wrap ops_done
    for (int i = 0; i < 260; i++) rand_step("wrap", 1'b1, 1'b1);
    // Random handshake traffic
    for (int i = 0; i < 200; i++) rand_step("rand", 1'($urandom), 1'($urandom));
    while (mcount != 0) rand_step("drain_end", 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
